// File: rtl/load_use_fwd_ctrl_if.sv
// Bundle of pipeline-side signals seen by the load-use hazard controller.
// The pipeline drives through the master modport; the controller uses the slave modport.
interface load_use_fwd_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    // Pipeline control
    logic              flush;
    logic              pipe_stall_in;
    logic              perf_clr;

    // MEM stage
    logic              mem_valid;
    logic              mem_is_load;
    logic [REG_AW-1:0] mem_dst;
    logic              mem_load_rdy;
    logic [DATA_W-1:0] mem_load_data;

    // EXE stage
    logic              exe_valid;
    logic [REG_AW-1:0] exe_rs;
    logic [REG_AW-1:0] exe_rt;
    logic              exe_opr1_use_gpr;
    logic              exe_opr2_use_gpr;
    logic              exe_rt_use;
    logic [DATA_W-1:0] ori_opr1;
    logic [DATA_W-1:0] ori_opr2;
    logic [DATA_W-1:0] ori_rt;

    // Controller results
    logic [DATA_W-1:0] valid_opr1;
    logic [DATA_W-1:0] valid_opr2;
    logic [DATA_W-1:0] valid_rt;
    logic              lu_stall;
    logic              lu_timeout;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output flush, pipe_stall_in, perf_clr,
        output mem_valid, mem_is_load, mem_dst, mem_load_rdy, mem_load_data,
        output exe_valid, exe_rs, exe_rt, exe_opr1_use_gpr, exe_opr2_use_gpr, exe_rt_use,
        output ori_opr1, ori_opr2, ori_rt,
        input  valid_opr1, valid_opr2, valid_rt, lu_stall, lu_timeout, stall_cnt
    );

    modport slave (
        input  flush, pipe_stall_in, perf_clr,
        input  mem_valid, mem_is_load, mem_dst, mem_load_rdy, mem_load_data,
        input  exe_valid, exe_rs, exe_rt, exe_opr1_use_gpr, exe_opr2_use_gpr, exe_rt_use,
        input  ori_opr1, ori_opr2, ori_rt,
        output valid_opr1, valid_opr2, valid_rt, lu_stall, lu_timeout, stall_cnt
    );
endinterface

// File: rtl/load_use_fwd_ctrl.sv
// Load-use hazard controller for the EXE stage: forwards MEM load data, stalls while a
// load is outstanding, buffers captured load data while EXE is held, counts stall cycles
// and raises a sticky watchdog flag when a stall lasts too long.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no load-use stall in progress
// S_WAIT  | stalling on an outstanding load, counting consecutive cycles
// S_TMO   | stall exceeded MAX_WAIT cycles; still stalling, timeout flagged
module load_use_fwd_ctrl #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input logic               clk,
    input logic               rst_n,
    load_use_fwd_ctrl_if.slave bus
);

    localparam int WC_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_TMO  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              lu_timeout_q, lu_timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              buf_vld_q, buf_vld_d;
    logic [REG_AW-1:0] buf_dst_q, buf_dst_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;

    logic mem_ld;
    logic hit_rs, hit_rt;
    logic need;
    logic lu_stall;
    logic exe_adv;
    logic capture;
    logic fwd_m1, fwd_m2, fwd_mrt;
    logic fwd_b1, fwd_b2, fwd_brt;

    // Hazard detection; register 0 is hard-zero so it never matches a load destination.
    always_comb begin
        mem_ld = bus.mem_valid & bus.mem_is_load & (bus.mem_dst != '0);
        hit_rs = bus.exe_valid & (bus.exe_rs != '0) & (bus.exe_rs == bus.mem_dst) & mem_ld;
        hit_rt = bus.exe_valid & (bus.exe_rt != '0) & (bus.exe_rt == bus.mem_dst) & mem_ld;
        need   = (hit_rs & bus.exe_opr1_use_gpr)
               | (hit_rt & (bus.exe_opr2_use_gpr | bus.exe_rt_use));
        // Gate with rst_n so the stall drops the instant reset asserts.
        lu_stall = need & ~bus.mem_load_rdy & rst_n;
        exe_adv  = bus.exe_valid & ~bus.pipe_stall_in & ~lu_stall;
        capture  = mem_ld & bus.mem_load_rdy & (hit_rs | hit_rt) & ~exe_adv & ~bus.flush;
    end

    // Operand source selection: ready MEM load beats the buffer, buffer beats original.
    always_comb begin
        fwd_m1  = hit_rs & bus.exe_opr1_use_gpr & bus.mem_load_rdy;
        fwd_m2  = hit_rt & bus.exe_opr2_use_gpr & bus.mem_load_rdy;
        fwd_mrt = hit_rt & bus.mem_load_rdy;
        fwd_b1  = buf_vld_q & (bus.exe_rs == buf_dst_q) & bus.exe_opr1_use_gpr;
        fwd_b2  = buf_vld_q & (bus.exe_rt == buf_dst_q) & bus.exe_opr2_use_gpr;
        fwd_brt = buf_vld_q & (bus.exe_rt == buf_dst_q);

        bus.valid_opr1 = bus.ori_opr1;
        if (fwd_m1)      bus.valid_opr1 = bus.mem_load_data;
        else if (fwd_b1) bus.valid_opr1 = buf_data_q;

        bus.valid_opr2 = bus.ori_opr2;
        if (fwd_m2)      bus.valid_opr2 = bus.mem_load_data;
        else if (fwd_b2) bus.valid_opr2 = buf_data_q;

        bus.valid_rt = bus.ori_rt;
        if (fwd_mrt)      bus.valid_rt = bus.mem_load_data;
        else if (fwd_brt) bus.valid_rt = buf_data_q;
    end

    // Load-data buffer next state; flush beats capture, capture replaces any older entry.
    always_comb begin
        buf_vld_d  = buf_vld_q;
        buf_dst_d  = buf_dst_q;
        buf_data_d = buf_data_q;
        if (bus.flush) begin
            buf_vld_d = 1'b0;
        end else if (capture) begin
            buf_vld_d  = 1'b1;
            buf_dst_d  = bus.mem_dst;
            buf_data_d = bus.mem_load_data;
        end else if (exe_adv) begin
            buf_vld_d = 1'b0;
        end
    end

    // Stall-duration FSM and sticky watchdog next state.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        lu_timeout_d = lu_timeout_q;
        if (bus.flush) begin
            state_d    = S_IDLE;
            wait_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (lu_stall) begin
                        state_d    = S_WAIT;
                        wait_cnt_d = WC_W'(1);
                    end
                end
                S_WAIT: begin
                    if (!lu_stall) begin
                        state_d    = S_IDLE;
                        wait_cnt_d = '0;
                    end else if (wait_cnt_q == WC_W'(MAX_WAIT - 1)) begin
                        state_d      = S_TMO;
                        lu_timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WC_W'(1);
                    end
                end
                S_TMO: begin
                    if (!lu_stall) begin
                        state_d    = S_IDLE;
                        wait_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = S_IDLE;
                    wait_cnt_d = '0;
                end
            endcase
        end
    end

    // Saturating stall-cycle counter; a clear request suppresses that cycle's increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.perf_clr) begin
            stall_cnt_d = '0;
        end else if (lu_stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers; everything, including buffered data, is discarded on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= '0;
            lu_timeout_q <= 1'b0;
            stall_cnt_q  <= '0;
            buf_vld_q    <= 1'b0;
            buf_dst_q    <= '0;
            buf_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            lu_timeout_q <= lu_timeout_d;
            stall_cnt_q  <= stall_cnt_d;
            buf_vld_q    <= buf_vld_d;
            buf_dst_q    <= buf_dst_d;
            buf_data_q   <= buf_data_d;
        end
    end

    assign bus.lu_stall   = lu_stall;
    assign bus.lu_timeout = lu_timeout_q;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_load_use_fwd_ctrl.sv
// Directed bench for load_use_fwd_ctrl. A second instance with a 4-bit stall counter
// exercises counter saturation without a 64k-cycle stall.
module tb_load_use_fwd_ctrl;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 5;
    localparam int MAX_WAIT = 16;
    localparam int CNT_W    = 16;
    localparam int CNT_W2   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    load_use_fwd_ctrl_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W))  bus ();
    load_use_fwd_ctrl_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W2)) bus2 ();

    load_use_fwd_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    load_use_fwd_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W2)) dut2 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.flush = 0; bus.pipe_stall_in = 0; bus.perf_clr = 0;
        bus.mem_valid = 0; bus.mem_is_load = 0; bus.mem_dst = '0;
        bus.mem_load_rdy = 0; bus.mem_load_data = '0;
        bus.exe_valid = 0; bus.exe_rs = '0; bus.exe_rt = '0;
        bus.exe_opr1_use_gpr = 0; bus.exe_opr2_use_gpr = 0; bus.exe_rt_use = 0;
        bus.ori_opr1 = '0; bus.ori_opr2 = '0; bus.ori_rt = '0;
        bus2.flush = 0; bus2.pipe_stall_in = 0; bus2.perf_clr = 0;
        bus2.mem_valid = 0; bus2.mem_is_load = 0; bus2.mem_dst = '0;
        bus2.mem_load_rdy = 0; bus2.mem_load_data = '0;
        bus2.exe_valid = 0; bus2.exe_rs = '0; bus2.exe_rt = '0;
        bus2.exe_opr1_use_gpr = 0; bus2.exe_opr2_use_gpr = 0; bus2.exe_rt_use = 0;
        bus2.ori_opr1 = '0; bus2.ori_opr2 = '0; bus2.ori_rt = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    // Drive a load in MEM and a consumer in EXE reading rs.
    task automatic drive_lw_rs(input logic [4:0] dst, input logic rdy, input logic [31:0] data,
                               input logic [31:0] ori1);
        bus.mem_valid = 1; bus.mem_is_load = 1; bus.mem_dst = dst;
        bus.mem_load_rdy = rdy; bus.mem_load_data = data;
        bus.exe_valid = 1; bus.exe_rs = dst; bus.exe_opr1_use_gpr = 1;
        bus.ori_opr1 = ori1;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst_n = 0;
        drive_lw_rs(5'd8, 1'b0, 32'h0, 32'h0000_0055);
        #1;
        n_total++; if (bus.lu_stall !== 1'b0) $display("FAIL reset_stall got=%0b exp=0", bus.lu_stall); else n_pass++;
        n_total++; if (bus.lu_timeout !== 1'b0) $display("FAIL reset_timeout got=%0b exp=0", bus.lu_timeout); else n_pass++;
        n_total++; if (bus.valid_opr1 !== 32'h55) $display("FAIL reset_opr1 got=%h exp=00000055", bus.valid_opr1); else n_pass++;
        tick(); tick();
        n_total++; if (bus.stall_cnt !== 16'h0) $display("FAIL reset_cnt got=%h exp=0000", bus.stall_cnt); else n_pass++;
        clear_inputs();
        rst_n = 1;
        tick();
    endtask

    task automatic test_fwd_ready;
        clear_inputs();
        drive_lw_rs(5'd8, 1'b1, 32'hDEAD_BEEF, 32'h1);
        bus.exe_rt = 5'd3; bus.exe_opr2_use_gpr = 1; bus.ori_opr2 = 32'h22; bus.ori_rt = 32'h33;
        #1;
        n_total++; if (bus.valid_opr1 !== 32'hDEAD_BEEF) $display("FAIL fwd_opr1 got=%h exp=deadbeef", bus.valid_opr1); else n_pass++;
        n_total++; if (bus.lu_stall !== 1'b0) $display("FAIL fwd_nostall got=%0b exp=0", bus.lu_stall); else n_pass++;
        n_total++; if (bus.valid_opr2 !== 32'h22) $display("FAIL fwd_opr2_nohit got=%h exp=00000022", bus.valid_opr2); else n_pass++;
        // rs hits but opr1 not from GPR; rt hits for opr2 and rt.
        bus.exe_opr1_use_gpr = 0; bus.exe_rt = 5'd8;
        #1;
        n_total++; if (bus.valid_opr1 !== 32'h1) $display("FAIL fwd_opr1_nouse got=%h exp=00000001", bus.valid_opr1); else n_pass++;
        n_total++; if (bus.valid_opr2 !== 32'hDEAD_BEEF) $display("FAIL fwd_opr2 got=%h exp=deadbeef", bus.valid_opr2); else n_pass++;
        n_total++; if (bus.valid_rt !== 32'hDEAD_BEEF) $display("FAIL fwd_rt got=%h exp=deadbeef", bus.valid_rt); else n_pass++;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_multicycle;
        clear_inputs();
        bus.perf_clr = 1;
        tick();
        bus.perf_clr = 0;
        drive_lw_rs(5'd8, 1'b0, 32'hCAFE_F00D, 32'h1);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++; if (bus.lu_stall !== 1'b1) $display("FAIL mc_stall[%0d] got=%0b exp=1", i, bus.lu_stall); else n_pass++;
            tick();
        end
        bus.mem_load_rdy = 1;
        #1;
        n_total++; if (bus.lu_stall !== 1'b0) $display("FAIL mc_release got=%0b exp=0", bus.lu_stall); else n_pass++;
        n_total++; if (bus.stall_cnt !== 16'd3) $display("FAIL mc_cnt got=%0d exp=3", bus.stall_cnt); else n_pass++;
        n_total++; if (bus.valid_opr1 !== 32'hCAFE_F00D) $display("FAIL mc_opr1 got=%h exp=cafef00d", bus.valid_opr1); else n_pass++;
        tick();
        n_total++; if (2'(dut.state_q) !== 2'd0) $display("FAIL mc_idle got=%0d exp=0", dut.state_q); else n_pass++;
        clear_inputs();
        tick();
    endtask

    task automatic test_buffer;
        clear_inputs();
        drive_lw_rs(5'd9, 1'b1, 32'h1234_5678, 32'h1111);
        bus.pipe_stall_in = 1;
        tick();
        tick();
        bus.mem_valid = 0; bus.mem_is_load = 0; bus.mem_load_data = 32'hFFFF_0000;
        bus.pipe_stall_in = 0;
        #1;
        n_total++; if (bus.valid_opr1 !== 32'h1234_5678) $display("FAIL buf_opr1 got=%h exp=12345678", bus.valid_opr1); else n_pass++;
        n_total++; if (bus.lu_stall !== 1'b0) $display("FAIL buf_nostall got=%0b exp=0", bus.lu_stall); else n_pass++;
        tick();
        n_total++; if (dut.buf_vld_q !== 1'b0) $display("FAIL buf_clr got=%0b exp=0", dut.buf_vld_q); else n_pass++;
        n_total++; if (bus.valid_opr1 !== 32'h1111) $display("FAIL buf_gone got=%h exp=00001111", bus.valid_opr1); else n_pass++;
        // MEM load beats a buffered entry for the same register.
        drive_lw_rs(5'd9, 1'b1, 32'hAAAA_0001, 32'h1111);
        bus.pipe_stall_in = 1;
        tick();
        bus.mem_load_data = 32'hBBBB_0002;
        #1;
        n_total++; if (bus.valid_opr1 !== 32'hBBBB_0002) $display("FAIL buf_prio got=%h exp=bbbb0002", bus.valid_opr1); else n_pass++;
        clear_inputs();
        bus.flush = 1;
        tick();
        bus.flush = 0;
        tick();
    endtask

    task automatic test_zero_reg;
        clear_inputs();
        bus.perf_clr = 1;
        tick();
        bus.perf_clr = 0;
        drive_lw_rs(5'd0, 1'b0, 32'h9999_9999, 32'h77);
        bus.exe_rt = 5'd0; bus.exe_rt_use = 1; bus.ori_rt = 32'h88;
        #1;
        n_total++; if (bus.lu_stall !== 1'b0) $display("FAIL zero_stall got=%0b exp=0", bus.lu_stall); else n_pass++;
        n_total++; if (bus.valid_opr1 !== 32'h77) $display("FAIL zero_opr1 got=%h exp=00000077", bus.valid_opr1); else n_pass++;
        bus.mem_load_rdy = 1;
        #1;
        n_total++; if (bus.valid_rt !== 32'h88) $display("FAIL zero_rt got=%h exp=00000088", bus.valid_rt); else n_pass++;
        tick();
        n_total++; if (bus.stall_cnt !== 16'd0) $display("FAIL zero_cnt got=%0d exp=0", bus.stall_cnt); else n_pass++;
        clear_inputs();
        tick();
    endtask

    task automatic test_timeout;
        do_reset();
        drive_lw_rs(5'd12, 1'b0, 32'h5A5A_5A5A, 32'h1);
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i >= 15) begin
                n_total++;
                if (bus.lu_timeout !== (i == 16)) $display("FAIL tmo_after_%0d got=%0b exp=%0b", i, bus.lu_timeout, (i == 16));
                else n_pass++;
            end
        end
        n_total++; if (bus.stall_cnt !== 16'd16) $display("FAIL tmo_cnt got=%0d exp=16", bus.stall_cnt); else n_pass++;
        n_total++; if (bus.lu_stall !== 1'b1) $display("FAIL tmo_still_stall got=%0b exp=1", bus.lu_stall); else n_pass++;
        bus.mem_load_rdy = 1;
        tick();
        n_total++; if (2'(dut.state_q) !== 2'd0) $display("FAIL tmo_idle got=%0d exp=0", dut.state_q); else n_pass++;
        clear_inputs();
        tick();
        n_total++; if (bus.lu_timeout !== 1'b1) $display("FAIL tmo_sticky got=%0b exp=1", bus.lu_timeout); else n_pass++;
        rst_n = 0;
        #1;
        n_total++; if (bus.lu_timeout !== 1'b0) $display("FAIL tmo_rst got=%0b exp=0", bus.lu_timeout); else n_pass++;
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_flush;
        do_reset();
        drive_lw_rs(5'd10, 1'b1, 32'hABCD_0001, 32'h1);
        bus.pipe_stall_in = 1;
        tick();
        drive_lw_rs(5'd11, 1'b0, 32'h0, 32'h1);
        bus.pipe_stall_in = 0;
        #1;
        n_total++; if (bus.lu_stall !== 1'b1) $display("FAIL fl_stall got=%0b exp=1", bus.lu_stall); else n_pass++;
        tick();
        n_total++; if (2'(dut.state_q) !== 2'd1) $display("FAIL fl_wait got=%0d exp=1", dut.state_q); else n_pass++;
        n_total++; if (dut.buf_vld_q !== 1'b1) $display("FAIL fl_bufset got=%0b exp=1", dut.buf_vld_q); else n_pass++;
        bus.flush = 1;
        tick();
        n_total++; if (2'(dut.state_q) !== 2'd0) $display("FAIL fl_idle got=%0d exp=0", dut.state_q); else n_pass++;
        n_total++; if (dut.buf_vld_q !== 1'b0) $display("FAIL fl_bufclr got=%0b exp=0", dut.buf_vld_q); else n_pass++;
        clear_inputs();
        tick();
    endtask

    task automatic test_back_to_back;
        clear_inputs();
        drive_lw_rs(5'd3, 1'b1, 32'h0000_000A, 32'h10);
        bus.exe_rt = 5'd4; bus.exe_opr2_use_gpr = 1; bus.ori_opr2 = 32'h20;
        #1;
        n_total++; if (bus.valid_opr1 !== 32'hA) $display("FAIL b2b_a_opr1 got=%h exp=0000000a", bus.valid_opr1); else n_pass++;
        n_total++; if (bus.valid_opr2 !== 32'h20) $display("FAIL b2b_a_opr2 got=%h exp=00000020", bus.valid_opr2); else n_pass++;
        tick();
        bus.mem_dst = 5'd4; bus.mem_load_data = 32'h0000_000B;
        bus.exe_rs = 5'd5; bus.ori_opr1 = 32'h30;
        #1;
        n_total++; if (bus.valid_opr1 !== 32'h30) $display("FAIL b2b_b_opr1 got=%h exp=00000030", bus.valid_opr1); else n_pass++;
        n_total++; if (bus.valid_opr2 !== 32'hB) $display("FAIL b2b_b_opr2 got=%h exp=0000000b", bus.valid_opr2); else n_pass++;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_saturate;
        clear_inputs();
        bus2.mem_valid = 1; bus2.mem_is_load = 1; bus2.mem_dst = 5'd8; bus2.mem_load_rdy = 0;
        bus2.exe_valid = 1; bus2.exe_rs = 5'd8; bus2.exe_opr1_use_gpr = 1;
        for (int i = 0; i < 17; i++) tick();
        n_total++; if (bus2.stall_cnt !== 4'hF) $display("FAIL sat_cnt got=%h exp=f", bus2.stall_cnt); else n_pass++;
        bus2.perf_clr = 1;
        tick();
        n_total++; if (bus2.stall_cnt !== 4'h0) $display("FAIL sat_clr got=%h exp=0", bus2.stall_cnt); else n_pass++;
        bus2.perf_clr = 0;
        tick();
        n_total++; if (bus2.stall_cnt !== 4'h1) $display("FAIL sat_restart got=%h exp=1", bus2.stall_cnt); else n_pass++;
        tick();
        rst_n = 0;
        #1;
        n_total++; if (bus2.lu_stall !== 1'b0) $display("FAIL sat_rst_stall got=%0b exp=0", bus2.lu_stall); else n_pass++;
        n_total++; if (bus2.stall_cnt !== 4'h0) $display("FAIL sat_rst_cnt got=%h exp=0", bus2.stall_cnt); else n_pass++;
        clear_inputs();
        tick();
        rst_n = 1;
        tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_fwd_ready();
        test_multicycle();
        test_buffer();
        test_zero_reg();
        test_back_to_back();
        test_timeout();
        test_flush();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
